// File: rtl/eth_types_pkg.sv
// rtl/eth_types_pkg.sv - shared Ethernet types and constants.
package eth_types_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_XFER,
    TX_DRAIN,
    TX_IFG
  } tx_arb_state;

  localparam int ETH_MAX_FRAME = 1514;
  localparam int ETH_IFG_CLKS  = 48;

endpackage

// File: rtl/eth_rr_pick.sv
// rtl/eth_rr_pick.sv - combinational round-robin picker.
// Searches upward from ptr_i+1, wrapping, and returns the first set request.
module eth_rr_pick #(
  parameter  int N    = 2,
  localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] ptr_i,
  output logic [N-1:0]    pick_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  int j;

  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    j      = 0;
    // Walk from the farthest candidate inward so the nearest one wins.
    for (int k = N; k >= 1; k--) begin
      j = (int'(ptr_i) + k) % N;
      if (req_i[j]) begin
        pick_o    = '0;
        pick_o[j] = 1'b1;
        idx_o     = IDXW'(j);
        any_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - round-robin whole-frame TX arbiter with IFG and truncation.
module eth_tx_arbiter
  import eth_types_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int IFG_CYCLES      = ETH_IFG_CLKS,
  parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic                 tx_last,
  input  logic                 tx_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 frame_trunc
);

  localparam int          IDXW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          IFGW     = $clog2(IFG_CYCLES) + 1;
  localparam logic [15:0] LAST_CNT = 16'(MAX_FRAME_BYTES - 1);

  tx_arb_state          state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [15:0]          byte_cnt_q, byte_cnt_d;
  logic [IFGW-1:0]      ifg_cnt_q, ifg_cnt_d;
  logic                 trunc_q, trunc_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [IDXW-1:0]      pick_idx;
  logic                 any_req;
  logic                 g_valid, g_last, at_limit;
  logic [7:0]           g_data;

  eth_rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i  (req_valid),
    .ptr_i  (rr_ptr_q),
    .pick_o (pick_onehot),
    .idx_o  (pick_idx),
    .any_o  (any_req)
  );

  // rr_ptr_q doubles as the index of the granted requester while a grant is held.
  assign g_valid  = req_valid[rr_ptr_q];
  assign g_last   = req_last[rr_ptr_q];
  assign g_data   = req_data[{rr_ptr_q, 3'b000} +: 8];
  assign at_limit = (byte_cnt_q == LAST_CNT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= TX_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= IDXW'(NUM_REQ - 1);
      byte_cnt_q <= '0;
      ifg_cnt_q  <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      ifg_cnt_q  <= ifg_cnt_d;
      trunc_q    <= trunc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    ifg_cnt_d  = ifg_cnt_q;
    trunc_d    = 1'b0;
    tx_data    = '0;
    tx_valid   = 1'b0;
    tx_last    = 1'b0;
    req_ready  = '0;

    unique case (state_q)
      TX_IDLE: begin
        byte_cnt_d = '0;
        if (any_req) begin
          grant_d  = pick_onehot;
          rr_ptr_d = pick_idx;
          state_d  = TX_XFER;
        end
      end
      TX_XFER: begin
        tx_data             = g_data;
        tx_valid            = g_valid;
        tx_last             = g_last | at_limit;
        req_ready[rr_ptr_q] = tx_ready;
        if (g_valid && tx_ready) begin
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (g_last) begin
            grant_d   = '0;
            ifg_cnt_d = IFGW'(IFG_CYCLES - 1);
            state_d   = TX_IFG;
          end else if (at_limit) begin
            trunc_d = 1'b1;
            state_d = TX_DRAIN;
          end
        end
      end
      TX_DRAIN: begin
        req_ready[rr_ptr_q] = 1'b1;
        if (g_valid && g_last) begin
          grant_d   = '0;
          ifg_cnt_d = IFGW'(IFG_CYCLES - 1);
          state_d   = TX_IFG;
        end
      end
      TX_IFG: begin
        if (ifg_cnt_q == '0) state_d = TX_IDLE;
        else                 ifg_cnt_d = ifg_cnt_q - 1'b1;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign grant       = grant_q;
  assign busy        = (state_q != TX_IDLE);
  assign frame_trunc = trunc_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - self-checking bench for eth_tx_arbiter.
module tb_eth_tx_arbiter;
  import eth_types_pkg::*;

  localparam int N    = 2;
  localparam int IFG  = ETH_IFG_CLKS;
  localparam int MAXB = ETH_MAX_FRAME;

  logic           clk = 1'b0;
  logic           reset;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [7:0]     tx_data;
  logic           tx_valid, tx_last, tx_ready;
  logic [N-1:0]   grant;
  logic           busy, frame_trunc;

  eth_tx_arbiter #(.NUM_REQ(N), .IFG_CYCLES(IFG), .MAX_FRAME_BYTES(MAXB)) dut (
    .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .frame_trunc(frame_trunc)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] exp_grant;
    logic [7:0]   exp_data;
  } tbl_t;
  tbl_t tbl [8];

  int checks, errors;
  logic [7:0] sq_data [N][$];
  bit         sq_last [N][$];
  int         sq_pos  [N];
  int         fr_len  [N][$];
  int         fr_base [N][$];
  logic [8:0] exp_q [$];
  int         exp_req [$];
  int model_last, cyc, last_end_cyc, first_tx_cyc, idle_gap;
  int trunc_seen, trunc_cyc, drain_cnt, exp_trunc, tx_count, ready_mode;
  bit in_frame, check_rdy, bubbles;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_frame(input int r, input int len, input int base);
    for (int k = 0; k < len; k++) begin
      sq_data[r].push_back(8'((base + k) & 255));
      sq_last[r].push_back(k == len - 1);
    end
    fr_len[r].push_back(len);
    fr_base[r].push_back(base);
  endtask

  // Reference: all frames are queued up front, so grant order is plain
  // round-robin over requesters that still have frames.
  task automatic build_expected();
    int r, len, base, n;
    bit more;
    more = 1;
    while (more) begin
      r = -1;
      for (int k = 1; k <= N; k++)
        if (r < 0 && fr_len[(model_last + k) % N].size() > 0) r = (model_last + k) % N;
      if (r < 0) more = 0;
      else begin
        model_last = r;
        len  = fr_len[r].pop_front();
        base = fr_base[r].pop_front();
        exp_req.push_back(r);
        n = (len > MAXB) ? MAXB : len;
        if (len > MAXB) exp_trunc++;
        for (int k = 0; k < n; k++) exp_q.push_back({k == n - 1, 8'((base + k) & 255)});
      end
    end
  endtask

  function automatic bit src_empty();
    for (int i = 0; i < N; i++) if (sq_data[i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic clear_stats();
    trunc_seen = 0; exp_trunc = 0; drain_cnt = 0; first_tx_cyc = -1;
    tx_count = 0; idle_gap = -2; trunc_cyc = -1;
  endtask

  task automatic step();
    logic [N-1:0]   v, l;
    logic [N*8-1:0] d;
    logic [8:0]     e;
    @(negedge clk);
    v = '0; l = '0; d = '0;
    for (int i = 0; i < N; i++) if (sq_data[i].size() > 0) begin
      d[i*8 +: 8] = sq_data[i][0];
      l[i] = sq_last[i][0];
      v[i] = !(bubbles && sq_pos[i] > 0 && $urandom_range(3) == 0);
    end
    req_valid = v; req_last = l; req_data = d;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ((cyc / 4) % 2 == 0);
      default: tx_ready = 1'($urandom_range(1));
    endcase
    #1;
    cyc++;
    if (frame_trunc) begin trunc_seen++; trunc_cyc = cyc; end
    if (idle_gap == -1 && !busy) idle_gap = cyc - last_end_cyc;
    if (check_rdy) check("req_ready_vs_tx_ready", 32'(req_ready), 32'(grant & {N{tx_ready}}));
    if (tx_valid && tx_ready) begin
      tx_count++;
      if (!in_frame) begin
        in_frame = 1;
        if (first_tx_cyc < 0) first_tx_cyc = cyc;
        check("ifg_gap_min", 32'(cyc - last_end_cyc >= IFG + 1), 1);
        if (exp_req.size() > 0) check("frame_grant", 32'(grant), 32'(1 << exp_req.pop_front()));
        else begin checks++; errors++; $display("FAIL extra_frame: got grant %0h expected no frame", grant); end
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("tx_last_data", 32'({tx_last, tx_data}), 32'(e));
      end else begin
        checks++; errors++;
        $display("FAIL tx_extra_byte: got %0h expected none", tx_data);
      end
      if (tx_last) begin in_frame = 0; last_end_cyc = cyc; idle_gap = -1; end
    end
    for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) begin
      if (!tx_valid) drain_cnt++;
      if (sq_data[i].size() > 0) begin
        sq_pos[i] = sq_last[i][0] ? 0 : sq_pos[i] + 1;
        sq_data[i].delete(0);
        sq_last[i].delete(0);
      end
    end
  endtask

  task automatic run_frames(input int budget);
    int n;
    bit done;
    n = 0; done = 0;
    clear_stats();
    build_expected();
    while (!done && n < budget) begin
      step();
      n++;
      done = (exp_q.size() == 0) && !busy && src_empty();
    end
    check("run_complete", 32'(done), 1);
    check("trunc_count", 32'(trunc_seen), 32'(exp_trunc));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin @(negedge clk); #1; n++; end
    check("wait_idle", 32'(busy), 0);
  endtask

  initial begin
    int c0, n;
    checks = 0; errors = 0; cyc = 0; last_end_cyc = -100000; model_last = N - 1;
    in_frame = 0; check_rdy = 1; bubbles = 0; ready_mode = 0;
    for (int i = 0; i < N; i++) sq_pos[i] = 0;
    clear_stats();
    tbl[0] = '{2'b11, 2'b01, 8'hA0};
    tbl[1] = '{2'b11, 2'b10, 8'hA1};
    tbl[2] = '{2'b01, 2'b01, 8'hA0};
    tbl[3] = '{2'b01, 2'b01, 8'hA0};
    tbl[4] = '{2'b10, 2'b10, 8'hA1};
    tbl[5] = '{2'b10, 2'b10, 8'hA1};
    tbl[6] = '{2'b11, 2'b01, 8'hA0};
    tbl[7] = '{2'b11, 2'b10, 8'hA1};

    reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    req_valid = '1; tx_ready = 1'b1;
    #1;
    check("rst_tx", 32'({tx_valid, tx_last, tx_data}), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_grant_busy_trunc", 32'({grant, busy, frame_trunc}), 0);
    @(negedge clk);
    req_valid = '0;
    reset = 1'b0;

    // Arbitration table: single-byte frames, round-robin state carried across rows.
    for (int t = 0; t < 8; t++) begin
      wait_idle();
      @(negedge clk);
      req_valid = tbl[t].valid; req_last = '1; req_data = 16'hA1A0; tx_ready = 1'b1;
      #1;
      check("tbl_idle_no_tx", 32'({tx_valid, grant}), 0);
      @(negedge clk); #1;
      check("tbl_grant", 32'(grant), 32'(tbl[t].exp_grant));
      check("tbl_tx_data", 32'(tx_data), 32'(tbl[t].exp_data));
      check("tbl_valid_last", 32'({tx_valid, tx_last}), 32'(2'b11));
      req_valid = tbl[t].exp_grant;
      @(negedge clk);
      req_valid = '0;
    end
    wait_idle();
    model_last = 1;

    // 60-byte frame: latency, ordering, busy until IFG + IDLE cycle.
    add_frame(0, 60, 0);
    c0 = cyc;
    run_frames(400);
    check("t1_first_byte_latency", 32'(first_tx_cyc - c0), 2);
    check("t1_busy_gap", 32'(idle_gap), 32'(IFG + 1));

    // Three 20-byte frames from each requester, alternating grants.
    for (int f = 0; f < 3; f++) begin
      add_frame(0, 20, 16 * f);
      add_frame(1, 20, 128 + 16 * f);
    end
    run_frames(1000);

    // tx_ready toggling every 4 cycles.
    ready_mode = 1;
    add_frame(1, 64, 9);
    run_frames(600);
    ready_mode = 0;

    // Oversize frame: truncated at MAXB, remainder drained.
    check_rdy = 0;
    add_frame(1, 1600, 7);
    run_frames(4000);
    check("t4_tx_bytes", 32'(tx_count), 32'(MAXB));
    check("t4_drained", 32'(drain_cnt), 32'(1600 - MAXB));
    check("t4_trunc_timing", 32'(trunc_cyc), 32'(last_end_cyc + 1));

    // Exactly MAXB bytes ends normally.
    add_frame(0, MAXB, 3);
    run_frames(4000);
    check("t5_tx_bytes", 32'(tx_count), 32'(MAXB));
    check("t5_no_drain", 32'(drain_cnt), 0);
    check_rdy = 1;

    // Random lengths, bubbles and backpressure.
    bubbles = 1; ready_mode = 2;
    for (int f = 0; f < 5; f++)
      for (int r = 0; r < N; r++) add_frame(r, $urandom_range(40, 1), $urandom_range(255));
    run_frames(6000);
    bubbles = 0; ready_mode = 0;

    // Reset mid-frame, then requester 0 wins first again.
    add_frame(0, 60, 64);
    clear_stats();
    build_expected();
    n = 0;
    while (tx_count < 30 && n < 200) begin step(); n++; end
    check("t6_reached_byte30", 32'(tx_count), 30);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_tx_valid", 32'(tx_valid), 0);
    check("t6_rst_grant", 32'(grant), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_req_ready", 32'(req_ready), 0);
    for (int i = 0; i < N; i++) begin sq_data[i].delete(); sq_last[i].delete(); sq_pos[i] = 0; end
    exp_q.delete(); exp_req.delete();
    in_frame = 0; last_end_cyc = -100000; model_last = N - 1;
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    add_frame(0, 5, 200);
    add_frame(1, 5, 100);
    run_frames(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
